issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
//  In-order issue sequencer between the instruction fetcher and the back end.
//  Buffers fetched instructions in a circular queue and presents the head
//  instruction to the combinational decoder. When the ROB and the target
//  station can accept it, issues the decoded fields as one registered pulse.
//  The target station is the LSB when is_ls=1, otherwise the RS.
//  Also owns queue flush on misprediction and optional control-op serialisation.
// PARAMETERS
//  IQ_DEPTH       8  queue entries; must be a power of 2 and at least 2
//  OPENUM_W       6  width of the decoder opcode-enum field
//  SERIALIZE_CTRL 0  1: after issuing an is_ctrl op, stop issuing until ctrl_done
// PORTS
//  clk           in   1        clock; all state updates on the rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  rdy           in   1        global enable; 0 freezes all state
//  flush         in   1        misprediction; discard all queued and pending work
//  ctrl_done     in   1        a serialised control op has resolved
//  if_valid      in   1        fetcher offers an instruction
//  if_inst       in   32       offered instruction word
//  if_pc         in   32       PC of the offered instruction
//  if_ready      out  1        queue accepts; equals rdy && !flush && count<IQ_DEPTH
//  dec_inst      out  32       head instruction word driven to the decoder
//  dec_is_ctrl   in   1        decoder result for dec_inst (same cycle)
//  dec_is_ls     in   1        decoder result for dec_inst
//  dec_openum    in   OPENUM_W decoder result for dec_inst
//  dec_rd        in   5        decoder result for dec_inst
//  dec_rs1       in   5        decoder result for dec_inst
//  dec_rs2       in   5        decoder result for dec_inst
//  dec_imm       in   32       decoder result for dec_inst
//  rob_full      in   1        ROB cannot take an entry next cycle
//  rs_full       in   1        RS cannot take an entry next cycle
//  lsb_full      in   1        LSB cannot take an entry next cycle
//  issue_valid   out  1        one-cycle pulse: issue_* fields are valid
//  issue_to_lsb  out  1        1: route to LSB; 0: route to RS
//  issue_is_ctrl out  1        registered copy of dec_is_ctrl
//  issue_pc      out  32       registered copy of the head PC
//  issue_openum  out  OPENUM_W registered copy of dec_openum
//  issue_rd      out  5        registered copy of dec_rd
//  issue_rs1     out  5        registered copy of dec_rs1
//  issue_rs2     out  5        registered copy of dec_rs2
//  issue_imm     out  32       registered copy of dec_imm
// BEHAVIOUR
//  Reset:
//   - head, tail, count and state go to 0/RUN.
//   - All issue_* outputs reset to 0.
//   - dec_inst reads 0 while the queue is empty.
//  Queue:
//   - Push when if_valid && if_ready: write at tail, then tail+1.
//   - Pointers are log2(IQ_DEPTH) bits and wrap modulo IQ_DEPTH.
//   - count is log2(IQ_DEPTH)+1 bits.
//   - Push and pop in the same cycle leave count unchanged.
//   - A push into a full queue is impossible because if_ready is 0.
//  Issue condition, go:
//   - go = rdy && !flush && count!=0 && state==RUN && !rob_full
//     && (dec_is_ls ? !lsb_full : !rs_full).
//   - On go: pop the head and register all decoder fields into issue_*.
//   - issue_valid=1 for exactly the next cycle, so latency is 1 clock from go.
//   - If go is 0, issue_valid=0 next cycle; the issue_* fields hold their old values.
//   - Full inputs already account for the in-flight issue; this block adds no margin.
//  FSM:
//   - RUN -> WAIT_CTRL when go && dec_is_ctrl && SERIALIZE_CTRL.
//   - WAIT_CTRL -> RUN on ctrl_done.
//   - ctrl_done seen while in RUN is ignored.
//  Flush (highest priority):
//   - Next edge: head=tail=count=0, state=RUN, issue_valid=0.
//   - A same-cycle push is dropped; if_ready is 0 that cycle anyway.
//   - A same-cycle pop does not happen.
//  rdy=0: no push, no pop, no FSM move; issue_valid is forced to 0.
//  Reset asserted mid-operation: queue contents are lost immediately.
// TESTING
//  1. Reset, push 3 (pc 0,4,8), all fulls 0:
//     -> issue_valid pulses on 3 consecutive cycles; pc 0,4,8 in order.
//  2. Push 8 with rob_full=1: -> if_ready=0 after 8 pushes.
//     Release rob_full -> 8 issues; if_ready returns 1 after the first pop.
//  3. dec_is_ls=1 head with lsb_full=1, rs_full=0 -> no issue.
//     Drop lsb_full -> issue_to_lsb=1 on the following cycle.
//  4. SERIALIZE_CTRL=1, queue holds JAL then ADDI -> JAL issues, ADDI held.
//     ctrl_done pulse -> ADDI issues 1 cycle later.
//  5. Queue holds 5, flush with if_valid=1 -> next cycle count=0, no issue.
//     The flushed-cycle instruction is absent from later issues.
//  6. Wrap: 20 push/pop pairs with simultaneous push+pop -> count stays at 1.
//     PCs are issued in order across the pointer wrap.

Source files
------------

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
//   In-order issue sequencer between the instruction fetcher and the back end.
//   Fetched instructions are buffered in a circular queue. The head entry is
//   presented to an external combinational decoder. When the ROB and the
//   target station (LSB for loads/stores, RS otherwise) have room, the decoded
//   fields are issued as a single registered pulse. The block also performs the
//   queue flush on misprediction. It can optionally serialise control ops: after
//   a control op issues, issue stalls until ctrl_done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global enable; 0 freezes all state
//   flush               misprediction: drop queued work on the next edge
//   ctrl_done           a serialised control op has resolved
//   if_valid/if_inst/if_pc/if_ready   fetcher push handshake
//   dec_inst            head instruction word (0 while the queue is empty)
//   dec_*               decoder results for dec_inst, same cycle
//   rob_full/rs_full/lsb_full         back-end back-pressure
//   issue_valid         one-cycle pulse; issue_* hold their values otherwise
//   issue_*             registered decoder fields and the head PC
// -----------------------------------------------------------------------------
module issue_ctrl #(
    parameter int IQ_DEPTH       = 8,
    parameter int OPENUM_W       = 6,
    parameter bit SERIALIZE_CTRL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                flush,
    input  logic                ctrl_done,
    input  logic                if_valid,
    input  logic [31:0]         if_inst,
    input  logic [31:0]         if_pc,
    output logic                if_ready,
    output logic [31:0]         dec_inst,
    input  logic                dec_is_ctrl,
    input  logic                dec_is_ls,
    input  logic [OPENUM_W-1:0] dec_openum,
    input  logic [4:0]          dec_rd,
    input  logic [4:0]          dec_rs1,
    input  logic [4:0]          dec_rs2,
    input  logic [31:0]         dec_imm,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    output logic                issue_valid,
    output logic                issue_to_lsb,
    output logic                issue_is_ctrl,
    output logic [31:0]         issue_pc,
    output logic [OPENUM_W-1:0] issue_openum,
    output logic [4:0]          issue_rd,
    output logic [4:0]          issue_rs1,
    output logic [4:0]          issue_rs2,
    output logic [31:0]         issue_imm
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_CTRL = 1'b1
    } state_e;

    // Queue storage and control.
    logic [31:0]      inst_mem [IQ_DEPTH];
    logic [31:0]      pc_mem   [IQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q;

    // Issue registers.
    logic                issue_valid_q;
    logic                issue_to_lsb_q;
    logic                issue_is_ctrl_q;
    logic [31:0]         issue_pc_q;
    logic [OPENUM_W-1:0] issue_openum_q;
    logic [4:0]          issue_rd_q;
    logic [4:0]          issue_rs1_q;
    logic [4:0]          issue_rs2_q;
    logic [31:0]         issue_imm_q;

    logic push;
    logic go;
    logic not_empty;
    logic station_free;

    assign not_empty    = (count_q != '0);
    assign if_ready     = rdy && !flush && (count_q < DEPTH_C);
    assign dec_inst     = not_empty ? inst_mem[head_q] : '0;
    // The target station is chosen by the decoded is_ls bit of the head entry.
    assign station_free = dec_is_ls ? !lsb_full : !rs_full;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = if_valid && if_ready;
        go      = rdy && !flush && not_empty && (state_q == RUN)
                  && !rob_full && station_free;

        // rdy gates everything. With rdy=1, flush overrides any push or pop.
        if (rdy) begin
            if (flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) tail_d = tail_q + PTR_W'(1);
                if (go)   head_d = head_q + PTR_W'(1);
                case ({push, go})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // NOTE: queue storage has no reset. Its contents are meaningless while
    // count is 0, so resetting the pointers and count discards them.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= if_inst;
            pc_mem[tail_q]   <= if_pc;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= RUN;
            issue_valid_q   <= 1'b0;
            issue_to_lsb_q  <= 1'b0;
            issue_is_ctrl_q <= 1'b0;
            issue_pc_q      <= '0;
            issue_openum_q  <= '0;
            issue_rd_q      <= '0;
            issue_rs1_q     <= '0;
            issue_rs2_q     <= '0;
            issue_imm_q     <= '0;
        end else if (!rdy) begin
            issue_valid_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            issue_valid_q <= go;
            if (go) begin
                issue_to_lsb_q  <= dec_is_ls;
                issue_is_ctrl_q <= dec_is_ctrl;
                issue_pc_q      <= pc_mem[head_q];
                issue_openum_q  <= dec_openum;
                issue_rd_q      <= dec_rd;
                issue_rs1_q     <= dec_rs1;
                issue_rs2_q     <= dec_rs2;
                issue_imm_q     <= dec_imm;
            end
            if (flush) begin
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN:       if (go && dec_is_ctrl && SERIALIZE_CTRL) state_q <= WAIT_CTRL;
                    WAIT_CTRL: if (ctrl_done) state_q <= RUN;
                    default:   state_q <= RUN;
                endcase
            end
        end
    end

    assign issue_valid   = issue_valid_q;
    assign issue_to_lsb  = issue_to_lsb_q;
    assign issue_is_ctrl = issue_is_ctrl_q;
    assign issue_pc      = issue_pc_q;
    assign issue_openum  = issue_openum_q;
    assign issue_rd      = issue_rd_q;
    assign issue_rs1     = issue_rs1_q;
    assign issue_rs2     = issue_rs2_q;
    assign issue_imm     = issue_imm_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl
//   Scoreboard bench for issue_ctrl with serialisation enabled. A queue-based
//   reference model predicts each issue and pushes the expected record. A
//   monitor pops and compares records whenever issue_valid is seen. The
//   decoder is a fixed bit-slice stand-in, so the bench knows the expected
//   fields for every instruction word.
// -----------------------------------------------------------------------------
module tb_issue_ctrl;

    localparam int DEPTH = 8;
    localparam int OW    = 6;
    localparam bit SER   = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy, flush, ctrl_done, if_valid;
    logic [31:0]   if_inst, if_pc;
    logic          if_ready;
    logic [31:0]   dec_inst;
    logic          dec_is_ctrl, dec_is_ls;
    logic [OW-1:0] dec_openum;
    logic [4:0]    dec_rd, dec_rs1, dec_rs2;
    logic [31:0]   dec_imm;
    logic          rob_full, rs_full, lsb_full;
    logic          issue_valid, issue_to_lsb, issue_is_ctrl;
    logic [31:0]   issue_pc, issue_imm;
    logic [OW-1:0] issue_openum;
    logic [4:0]    issue_rd, issue_rs1, issue_rs2;

    always #5 clk = ~clk;

    // Stand-in decoder: fields are fixed slices of the instruction word.
    assign dec_is_ctrl = dec_inst[0];
    assign dec_is_ls   = dec_inst[1];
    assign dec_openum  = dec_inst[7:2];
    assign dec_rd      = dec_inst[12:8];
    assign dec_rs1     = dec_inst[17:13];
    assign dec_rs2     = dec_inst[22:18];
    assign dec_imm     = {dec_inst[15:0], dec_inst[31:16]};

    issue_ctrl #(.IQ_DEPTH(DEPTH), .OPENUM_W(OW), .SERIALIZE_CTRL(SER)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .ctrl_done(ctrl_done),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .dec_inst(dec_inst), .dec_is_ctrl(dec_is_ctrl), .dec_is_ls(dec_is_ls),
        .dec_openum(dec_openum), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .issue_valid(issue_valid), .issue_to_lsb(issue_to_lsb), .issue_is_ctrl(issue_is_ctrl),
        .issue_pc(issue_pc), .issue_openum(issue_openum), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        int            cyc;
        logic          to_lsb;
        logic          is_ctrl;
        logic [31:0]   pc;
        logic [OW-1:0] openum;
        logic [4:0]    rd, rs1, rs2;
        logic [31:0]   imm;
    } iss_t;

    ent_t mq[$];      // model of the instruction queue
    iss_t exq[$];     // expected issue records
    bit   m_wait;     // model: waiting for ctrl_done
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    iss_t last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic iss_t decode(input ent_t e);
        iss_t r;
        r.cyc     = 0;
        r.is_ctrl = e.inst[0];
        r.to_lsb  = e.inst[1];
        r.openum  = e.inst[7:2];
        r.rd      = e.inst[12:8];
        r.rs1     = e.inst[17:13];
        r.rs2     = e.inst[22:18];
        r.imm     = {e.inst[15:0], e.inst[31:16]};
        r.pc      = e.pc;
        return r;
    endfunction

    function automatic logic [31:0] mk(input bit ctrl, input bit ls, input logic [29:0] body);
        return {body, ls, ctrl};
    endfunction

    // Monitor: samples one time unit after each rising edge.
    always @(posedge clk) begin
        iss_t r;
        #1;
        cyc++;
        if (issue_valid) begin
            if (exq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_issue: got issue pc %0h expected no issue (cycle %0d)", issue_pc, cyc);
            end else begin
                r = exq.pop_front();
                check("issue_cycle",   cyc,           r.cyc);
                check("issue_pc",      issue_pc,      r.pc);
                check("issue_to_lsb",  issue_to_lsb,  r.to_lsb);
                check("issue_is_ctrl", issue_is_ctrl, r.is_ctrl);
                check("issue_openum",  issue_openum,  r.openum);
                check("issue_rd",      issue_rd,      r.rd);
                check("issue_rs1",     issue_rs1,     r.rs1);
                check("issue_rs2",     issue_rs2,     r.rs2);
                check("issue_imm",     issue_imm,     r.imm);
                last = r;
            end
        end else begin
            check("hold_pc",  issue_pc,  last.pc);
            check("hold_imm", issue_imm, last.imm);
        end
    end

    // Applies the current inputs for one cycle. It checks the combinational
    // outputs, advances the model and returns at the next falling edge.
    task automatic tick();
        bit   go, exp_ready;
        iss_t r;
        #1;
        exp_ready = rdy && !flush && (mq.size() < DEPTH);
        check("if_ready", if_ready, exp_ready);
        check("dec_inst", dec_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
        go = 1'b0;
        if (rdy && !flush && mq.size() != 0 && !m_wait && !rob_full)
            go = mq[0].inst[1] ? !lsb_full : !rs_full;
        if (rdy) begin
            if (flush) begin
                mq.delete();
                m_wait = 1'b0;
            end else begin
                if (go) begin
                    r     = decode(mq[0]);
                    r.cyc = cyc + 1;
                    exq.push_back(r);
                    void'(mq.pop_front());
                    if (SER && r.is_ctrl) m_wait = 1'b1;
                end else if (m_wait && ctrl_done) begin
                    m_wait = 1'b0;
                end
                if (if_valid && exp_ready) mq.push_back('{if_inst, if_pc});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; flush = 1'b0; ctrl_done = 1'b0; if_valid = 1'b0;
        if_inst = '0; if_pc = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1; if_inst = inst; if_pc = pc;
        tick();
        if_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        last   = '{default: '0};
        m_wait = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_issue_pc",    issue_pc,    32'h0);
        check("rst_issue_rd",    issue_rd,    5'h0);
        check("rst_issue_imm",   issue_imm,   32'h0);
        check("rst_dec_inst",    dec_inst,    32'h0);
        check("rst_if_ready",    if_ready,    1'b1);

        // 1: three pushes issue on consecutive cycles, in order
        for (int i = 0; i < 3; i++) push(mk(0, 0, 30'(32'h1000 + i)), 32'(i * 4));
        repeat (3) tick();

        // 2: fill with rob_full held, overfill attempt, then release
        rob_full = 1'b1;
        for (int i = 0; i < 8; i++) push(mk(0, i[0], 30'(32'h2200 + i * 37)), 32'h100 + 32'(i * 4));
        push(mk(0, 0, 30'h3fff), 32'hdead);
        check("full_if_ready", if_ready, 1'b0);
        rob_full = 1'b0;
        repeat (10) tick();

        // 3: load/store head blocked only by lsb_full
        lsb_full = 1'b1;
        push(mk(0, 1, 30'h0abcd), 32'h200);
        repeat (3) tick();
        lsb_full = 1'b0;
        repeat (2) tick();

        // 4: serialised control op holds the next instruction until ctrl_done
        push(mk(1, 0, 30'h006f), 32'h300);
        push(mk(0, 0, 30'h0093), 32'h304);
        repeat (4) tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        repeat (3) tick();

        // 5: flush with five queued and a same-cycle push
        rob_full = 1'b1;
        for (int i = 0; i < 5; i++) push(mk(0, 0, 30'(32'h4400 + i)), 32'h400 + 32'(i * 4));
        flush = 1'b1; if_valid = 1'b1; if_inst = mk(0, 0, 30'h5555); if_pc = 32'h4ff0;
        tick();
        flush = 1'b0; if_valid = 1'b0; rob_full = 1'b0;
        check("flush_dec_inst", dec_inst, 32'h0);
        repeat (3) tick();
        push(mk(0, 0, 30'h6601), 32'h500);
        repeat (2) tick();

        // 6: steady push+pop across the pointer wrap
        push(mk(0, 0, 30'h7000), 32'h600);
        for (int i = 1; i <= 20; i++) push(mk(0, 0, 30'(32'h7000 + i)), 32'h600 + 32'(i * 4));
        repeat (3) tick();

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = rdy && ($urandom_range(0, 39) == 0);
            ctrl_done = ($urandom_range(0, 4) == 0);
            rob_full  = ($urandom_range(0, 4) == 0);
            rs_full   = ($urandom_range(0, 3) == 0);
            lsb_full  = ($urandom_range(0, 3) == 0);
            if_valid  = ($urandom_range(0, 2) != 0);
            if_inst   = $urandom;
            if_pc     = $urandom;
            tick();
        end

        // Drain with a bounded number of cycles
        idle_inputs();
        ctrl_done = 1'b1;
        for (int n = 0; n < 64 && (mq.size() != 0 || exq.size() != 0); n++) tick();
        tick();
        check("drain_model_queue", 64'(mq.size()), 64'h0);
        check("drain_expected",    64'(exq.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
